// File: rtl/vxe_mem_arb3.sv
// Three-client memory port arbiter: per-client request FIFOs drained round-robin into one
// downstream request port, and shared in-order responses routed back by client ID.
module vxe_mem_arb3 #(
  parameter logic [5:0]  CLIENT0_ID = 6'd0,
  parameter logic [5:0]  CLIENT1_ID = 6'd1,
  parameter logic [5:0]  CLIENT2_ID = 6'd2,
  parameter int unsigned IFIFO_POW2 = 1
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [2:0]     i_rqa_wr,
  input  logic [3*44-1:0] i_rqa,
  output logic [2:0]     o_rqa_rdy,
  output logic           o_rqa_wr,
  output logic [43:0]    o_rqa,
  input  logic           i_rqa_rdy,
  input  logic           i_rss_vld,
  input  logic [8:0]     i_rss,
  output logic           o_rss_rd,
  input  logic           i_rsd_vld,
  input  logic [63:0]    i_rsd,
  output logic           o_rsd_rd,
  output logic [2:0]     o_rss_wr,
  output logic [8:0]     o_rss,
  output logic [63:0]    o_rsd,
  input  logic [2:0]     i_rss_rdy,
  output logic           o_rsp_err
);

  localparam int unsigned Depth = 1 << IFIFO_POW2;
  localparam int unsigned AW    = IFIFO_POW2;
  localparam int unsigned PtrW  = IFIFO_POW2 + 1;

  logic [PtrW-1:0] wr_ptr_q [3];
  logic [PtrW-1:0] wr_ptr_d [3];
  logic [PtrW-1:0] rd_ptr_q [3];
  logic [PtrW-1:0] rd_ptr_d [3];
  logic [43:0]     mem_q [3][Depth];
  logic [43:0]     mem_d [3][Depth];
  logic [2:0]      rdy_q, rdy_d;
  logic [1:0]      last_q, last_d;
  logic            err_q, err_d;

  logic [2:0] cand, grant, push, hit;
  logic [1:0] pick, idx;
  logic       found;
  logic       rsp_both, rsp_pop;

  // Round-robin pick: scan cyclically starting just after the last granted client.
  always_comb begin
    cand  = '0;
    pick  = '0;
    found = 1'b0;
    idx   = last_q;
    for (int k = 0; k < 3; k++) begin
      cand[k] = (wr_ptr_q[k] != rd_ptr_q[k]);
    end
    for (int i = 0; i < 3; i++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    o_rqa_wr = (|cand) & i_rqa_rdy;
    o_rqa    = mem_q[pick][rd_ptr_q[pick][AW-1:0]];
    grant    = o_rqa_wr ? (3'b001 << pick) : 3'b000;
    last_d   = o_rqa_wr ? pick : last_q;
  end

  // Ready is the registered inverse of the post-update full state, so a write is
  // accepted only when the client saw ready in that cycle.
  always_comb begin
    mem_d = mem_q;
    push  = '0;
    rdy_d = '0;
    for (int k = 0; k < 3; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
    end
    for (int k = 0; k < 3; k++) begin
      push[k] = i_rqa_wr[k] & rdy_q[k];
      if (push[k]) begin
        mem_d[k][wr_ptr_q[k][AW-1:0]] = i_rqa[44*k +: 44];
      end
      wr_ptr_d[k] = wr_ptr_q[k] + {{(PtrW-1){1'b0}}, push[k]};
      rd_ptr_d[k] = rd_ptr_q[k] + {{(PtrW-1){1'b0}}, grant[k]};
      rdy_d[k]    = ~((wr_ptr_d[k][AW] != rd_ptr_d[k][AW]) &&
                      (wr_ptr_d[k][AW-1:0] == rd_ptr_d[k][AW-1:0]));
    end
  end

  // Response path: pairs move only when both halves are present; unknown IDs are dropped.
  always_comb begin
    hit[0]   = (i_rss[8:3] == CLIENT0_ID);
    hit[1]   = (i_rss[8:3] == CLIENT1_ID);
    hit[2]   = (i_rss[8:3] == CLIENT2_ID);
    rsp_both = i_rss_vld & i_rsd_vld;
    rsp_pop  = rsp_both & ((|hit) ? (|(hit & i_rss_rdy)) : 1'b1);
    o_rss_rd = rsp_pop;
    o_rsd_rd = rsp_pop;
    o_rss_wr = {3{rsp_pop}} & hit;
    o_rss    = i_rss;
    o_rsd    = i_rsd;
    err_d    = err_q | (rsp_pop & ~(|hit));
  end

  assign o_rqa_rdy = rdy_q;
  assign o_rsp_err = err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < 3; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
      rdy_q  <= '0;
      last_q <= 2'd2;
      err_q  <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
      end
      rdy_q  <= rdy_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_vxe_mem_arb3.sv
// Bench for vxe_mem_arb3: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_vxe_mem_arb3;

  logic            clk = 1'b0;
  logic            nrst;
  logic [2:0]      i_rqa_wr;
  logic [3*44-1:0] i_rqa;
  logic [2:0]      o_rqa_rdy;
  logic            o_rqa_wr;
  logic [43:0]     o_rqa;
  logic            i_rqa_rdy;
  logic            i_rss_vld;
  logic [8:0]      i_rss;
  logic            o_rss_rd;
  logic            i_rsd_vld;
  logic [63:0]     i_rsd;
  logic            o_rsd_rd;
  logic [2:0]      o_rss_wr;
  logic [8:0]      o_rss;
  logic [63:0]     o_rsd;
  logic [2:0]      i_rss_rdy;
  logic            o_rsp_err;

  vxe_mem_arb3 dut (
    .clk       (clk),
    .nrst      (nrst),
    .i_rqa_wr  (i_rqa_wr),
    .i_rqa     (i_rqa),
    .o_rqa_rdy (o_rqa_rdy),
    .o_rqa_wr  (o_rqa_wr),
    .o_rqa     (o_rqa),
    .i_rqa_rdy (i_rqa_rdy),
    .i_rss_vld (i_rss_vld),
    .i_rss     (i_rss),
    .o_rss_rd  (o_rss_rd),
    .i_rsd_vld (i_rsd_vld),
    .i_rsd     (i_rsd),
    .o_rsd_rd  (o_rsd_rd),
    .o_rss_wr  (o_rss_wr),
    .o_rss     (o_rss),
    .o_rsd     (o_rsd),
    .i_rss_rdy (i_rss_rdy),
    .o_rsp_err (o_rsp_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Reference model state
  logic [43:0] mq [3][$];
  int          last_m = 2;
  logic [2:0]  rdy_m  = 3'b000;
  logic        err_m  = 1'b0;

  // Observation logs for directed checks
  logic [43:0] rqa_log [$];
  logic [2:0]  wr_log  [$];
  logic [63:0] d_log   [$];
  int          pop_cnt = 0;

  // Inputs change at posedge+1, so at the negedge they are stable up to the next edge:
  // compare against the model, then advance the model to what that edge must do.
  always @(negedge clk) begin : compare
    int          pick;
    bit          any;
    bit          pop_e;
    logic [2:0]  hit_m;
    logic [5:0]  id;
    if (!nrst) begin
      for (int k = 0; k < 3; k++) mq[k].delete();
      last_m = 2;
      rdy_m  = 3'b000;
      err_m  = 1'b0;
      chk("rst_rqa_rdy", {61'd0, o_rqa_rdy}, 64'd0);
      chk("rst_rqa_wr", {63'd0, o_rqa_wr}, 64'd0);
      chk("rst_rsp_err", {63'd0, o_rsp_err}, 64'd0);
    end else begin
      any  = 1'b0;
      pick = 0;
      for (int i = 1; i <= 3; i++) begin
        int c;
        c = (last_m + i) % 3;
        if (!any && mq[c].size() > 0) begin
          any  = 1'b1;
          pick = c;
        end
      end
      chk("rqa_rdy", {61'd0, o_rqa_rdy}, {61'd0, rdy_m});
      chk("rqa_wr", {63'd0, o_rqa_wr}, {63'd0, any && i_rqa_rdy});
      if (any && i_rqa_rdy) begin
        chk("rqa_data", {20'd0, o_rqa}, {20'd0, mq[pick][0]});
        void'(mq[pick].pop_front());
        last_m = pick;
      end
      if (o_rqa_wr) rqa_log.push_back(o_rqa);
      for (int k = 0; k < 3; k++) begin
        if (i_rqa_wr[k] && rdy_m[k]) mq[k].push_back(i_rqa[44*k +: 44]);
      end
      for (int k = 0; k < 3; k++) rdy_m[k] = (mq[k].size() < 2);

      id = i_rss[8:3];
      for (int k = 0; k < 3; k++) hit_m[k] = (int'(id) == k);
      pop_e = i_rss_vld && i_rsd_vld &&
              ((hit_m != 3'b000) ? ((hit_m & i_rss_rdy) != 3'b000) : 1'b1);
      chk("rss_rd", {63'd0, o_rss_rd}, {63'd0, pop_e});
      chk("rsd_rd", {63'd0, o_rsd_rd}, {63'd0, pop_e});
      chk("rss_wr", {61'd0, o_rss_wr}, {61'd0, pop_e ? hit_m : 3'b000});
      chk("rsp_err", {63'd0, o_rsp_err}, {63'd0, err_m});
      if (pop_e) begin
        chk("rss_fwd", {55'd0, o_rss}, {55'd0, i_rss});
        chk("rsd_fwd", o_rsd, i_rsd);
        if (hit_m == 3'b000) err_m = 1'b1;
      end
      if (o_rss_rd) begin
        pop_cnt++;
        wr_log.push_back(o_rss_wr);
        d_log.push_back(o_rsd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [43:0] exp_rqa [6];

  initial begin
    nrst      = 1'b0;
    i_rqa_wr  = '0;
    i_rqa     = '0;
    i_rqa_rdy = 1'b0;
    i_rss_vld = 1'b0;
    i_rss     = '0;
    i_rsd_vld = 1'b0;
    i_rsd     = '0;
    i_rss_rdy = 3'b111;
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;

    // T1: ready asserted one cycle after release, everything else idle
    cyc();
    chk("t1_rqa_rdy", {61'd0, o_rqa_rdy}, 64'h7);
    chk("t1_rqa_wr", {63'd0, o_rqa_wr}, 64'd0);
    chk("t1_rss_wr", {61'd0, o_rss_wr}, 64'd0);
    chk("t1_rsp_err", {63'd0, o_rsp_err}, 64'd0);

    // T2: all clients write twice together; drain order must rotate c0,c1,c2
    exp_rqa = '{44'h0C0_0000_00A0, 44'h0C1_0000_00A1, 44'h0C2_0000_00A2,
                44'h0C0_0000_00B0, 44'h0C1_0000_00B1, 44'h0C2_0000_00B2};
    rqa_log.delete();
    i_rqa_rdy = 1'b1;
    i_rqa_wr  = 3'b111;
    i_rqa     = {exp_rqa[2], exp_rqa[1], exp_rqa[0]};
    cyc();
    i_rqa     = {exp_rqa[5], exp_rqa[4], exp_rqa[3]};
    cyc();
    i_rqa_wr  = '0;
    repeat (8) cyc();
    chk("t2_count", rqa_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rqa_log.size()) chk("t2_order", {20'd0, rqa_log[i]}, {20'd0, exp_rqa[i]});
    end

    // T3: fill client 1 under downstream backpressure, then release
    rqa_log.delete();
    i_rqa_rdy = 1'b0;
    i_rqa_wr  = 3'b010;
    i_rqa     = {44'd0, 44'h111_2222_3333, 44'd0};
    cyc();
    i_rqa     = {44'd0, 44'h444_5555_6666, 44'd0};
    cyc();
    i_rqa_wr  = '0;
    chk("t3_rdy_full", {61'd0, o_rqa_rdy}, 64'h5);
    chk("t3_no_wr", {63'd0, o_rqa_wr}, 64'd0);
    repeat (2) cyc();
    chk("t3_held", rqa_log.size(), 0);
    i_rqa_rdy = 1'b1;
    repeat (4) cyc();
    chk("t3_count", rqa_log.size(), 2);
    if (rqa_log.size() == 2) begin
      chk("t3_first", {20'd0, rqa_log[0]}, 64'h111_2222_3333);
      chk("t3_second", {20'd0, rqa_log[1]}, 64'h444_5555_6666);
    end
    chk("t3_rdy_back", {61'd0, o_rqa_rdy}, 64'h7);

    // T4: routing IDs 0,2,1 after a status-only cycle that must not pop
    pop_cnt = 0;
    wr_log.delete();
    d_log.delete();
    i_rss_vld = 1'b1;
    i_rss     = {6'd0, 3'd1};
    cyc();
    i_rsd_vld = 1'b1;
    i_rsd     = 64'h1111_0000_0000_0001;
    cyc();
    i_rss     = {6'd2, 3'd5};
    i_rsd     = 64'h2222_0000_0000_0002;
    i_rqa_wr  = 3'b100;
    i_rqa     = {44'h0AB_CDEF_0123, 88'd0};
    cyc();
    i_rqa_wr  = '0;
    i_rss     = {6'd1, 3'd3};
    i_rsd     = 64'h3333_0000_0000_0003;
    cyc();
    i_rss_vld = 1'b0;
    i_rsd_vld = 1'b0;
    cyc();
    chk("t4_pops", pop_cnt, 3);
    if (wr_log.size() == 3) begin
      chk("t4_wr0", {61'd0, wr_log[0]}, 64'h1);
      chk("t4_wr1", {61'd0, wr_log[1]}, 64'h4);
      chk("t4_wr2", {61'd0, wr_log[2]}, 64'h2);
      chk("t4_d0", d_log[0], 64'h1111_0000_0000_0001);
      chk("t4_d1", d_log[1], 64'h2222_0000_0000_0002);
      chk("t4_d2", d_log[2], 64'h3333_0000_0000_0003);
    end

    // T5: client 2 sink stalled holds the head; request path keeps running
    pop_cnt   = 0;
    i_rss_rdy = 3'b011;
    i_rss_vld = 1'b1;
    i_rsd_vld = 1'b1;
    i_rss     = {6'd2, 3'd0};
    i_rsd     = 64'h5555_AAAA_5555_AAAA;
    i_rqa_wr  = 3'b001;
    i_rqa     = {88'd0, 44'h0DE_AD00_BEEF};
    cyc();
    i_rqa_wr  = '0;
    repeat (4) cyc();
    chk("t5_stalled", pop_cnt, 0);
    i_rss_rdy = 3'b111;
    cyc();
    i_rss_vld = 1'b0;
    i_rsd_vld = 1'b0;
    chk("t5_released", pop_cnt, 1);

    // T6: unknown ID is discarded and flags a sticky error
    pop_cnt   = 0;
    i_rss_vld = 1'b1;
    i_rsd_vld = 1'b1;
    i_rss     = {6'h3F, 3'd7};
    i_rsd     = 64'hDEAD_BEEF_0000_0006;
    cyc();
    i_rss_vld = 1'b0;
    i_rsd_vld = 1'b0;
    chk("t6_popped", pop_cnt, 1);
    chk("t6_err", {63'd0, o_rsp_err}, 64'd1);
    repeat (3) cyc();
    chk("t6_err_sticky", {63'd0, o_rsp_err}, 64'd1);

    // Reset mid-operation drops queued requests and clears the error flag
    i_rqa_rdy = 1'b0;
    i_rqa_wr  = 3'b001;
    i_rqa     = {88'd0, 44'h077_7777_7777};
    cyc();
    cyc();
    i_rqa_wr  = '0;
    nrst      = 1'b0;
    cyc();
    chk("rst_err_clear", {63'd0, o_rsp_err}, 64'd0);
    nrst      = 1'b1;
    cyc();
    i_rqa_rdy = 1'b1;
    rqa_log.delete();
    repeat (3) cyc();
    chk("rst_flushed", rqa_log.size(), 0);
    chk("rst_err_after", {63'd0, o_rsp_err}, 64'd0);
    chk("rst_rdy_after", {61'd0, o_rqa_rdy}, 64'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
